// File: rtl/csr_register_file_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, mstatus bits, mcause codes.
// CSR_COUNTER_INHIBIT_EN adds mcountinhibit (0x320) to the implemented address map.
package csr_register_file_pkg;

   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MTVEC         = 12'h305;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_TIME          = 12'hC01;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_TIMEH         = 12'hC81;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
   localparam logic [11:0] CSR_MHARTID       = 12'hF14;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   localparam logic [31:0] MCAUSE_INSN_MISALIGNED = 32'd0;
   localparam logic [31:0] MCAUSE_ILLEGAL_INSN    = 32'd2;
   localparam logic [31:0] MCAUSE_BREAKPOINT      = 32'd3;
   localparam logic [31:0] MCAUSE_ECALL_M         = 32'd11;

   typedef struct packed {
      logic mpie;
      logic mie;
   } mstatus_t;

   function automatic logic csr_implemented(input logic [11:0] a);
      logic hit;
      hit = 1'b0;
      case (a)
         CSR_MSTATUS, CSR_MISA, CSR_MTVEC,
         CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
         CSR_MCYCLE, CSR_MINSTRET,
         CSR_MCYCLEH, CSR_MINSTRETH,
         CSR_CYCLE, CSR_TIME, CSR_INSTRET,
         CSR_CYCLEH, CSR_TIMEH, CSR_INSTRETH,
         CSR_MHARTID: hit = 1'b1;
`ifdef CSR_COUNTER_INHIBIT_EN
         CSR_MCOUNTINHIBIT: hit = 1'b1;
`endif
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/csr_register_file_if.sv
// CSR access bus between the pipeline (master) and the CSR file (slave).
// Read and write ports are independent; illegal_access covers both.
interface csr_register_file_if;

   logic        read_enable;
   logic [11:0] read_address;
   logic [31:0] read_data;
   logic        write_enable;
   logic [11:0] write_address;
   logic [31:0] write_data;
   logic        illegal_access;

   modport master (
      output read_enable, read_address,
      output write_enable, write_address, write_data,
      input  read_data, illegal_access
   );

   modport slave (
      input  read_enable, read_address,
      input  write_enable, write_address, write_data,
      output read_data, illegal_access
   );

endinterface

// File: rtl/csr_register_file_counter64.sv
// 64-bit counter with per-half software load; a load suppresses that cycle's increment.
// Carry from low to high word is folded into the single 64-bit add.
module csr_counter64 (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wr_data,
   output logic [63:0] value
);

   always_ff @(posedge clk) begin
      if (reset) begin
         value <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) value[31:0]  <= wr_data;
         if (wr_hi) value[63:32] <= wr_data;
      end else if (inc) begin
         value <= value + 64'd1;
      end
   end

endmodule

// File: rtl/csr_register_file.sv
// Machine-mode CSR file: storage, counters, trap/MRET state and access checking.
// Optional mcountinhibit at 0x320 when CSR_COUNTER_INHIBIT_EN is defined.
module csr_register_file
   import csr_register_file_pkg::*;
#(
   parameter logic [31:0] HART_ID     = 32'd0,
   parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   csr_register_file_if.slave         bus,
   input  logic                       instret_pulse,
   input  logic                       trap_valid,
   input  logic [31:0]                trap_pc,
   input  logic [31:0]                trap_cause,
   input  logic                       mret_valid,
   output logic [31:0]                mtvec_out,
   output logic [31:0]                mepc_out,
   output logic                       global_ie
);

   mstatus_t    mstatus;
   logic [31:0] mtvec;
   logic [31:0] mscratch;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic        cy_inh;
   logic        ir_inh;

   logic        rd_ill;
   logic        wr_ill;
   logic        wr_ok;
   logic [11:0] wa;
   logic [31:0] wd;
   logic [31:0] rmux;

   assign wa = bus.write_address;
   assign wd = bus.write_data;

   // Top two address bits 11 mark the read-only space.
   assign rd_ill = bus.read_enable && !csr_implemented(bus.read_address);
   assign wr_ill = bus.write_enable &&
                   (wa[11:10] == 2'b11 || !csr_implemented(wa));
   assign wr_ok  = bus.write_enable && !wr_ill;

   assign bus.illegal_access = rd_ill || wr_ill;

`ifdef CSR_COUNTER_INHIBIT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cy_inh <= 1'b0;
         ir_inh <= 1'b0;
      end else if (wr_ok && wa == CSR_MCOUNTINHIBIT) begin
         cy_inh <= wd[0];
         ir_inh <= wd[2];
      end
   end
`else
   assign cy_inh = 1'b0;
   assign ir_inh = 1'b0;
`endif

   csr_counter64 u_cycle (
      .clk     (clk),
      .reset   (reset),
      .inc     (!cy_inh),
      .wr_lo   (wr_ok && wa == CSR_MCYCLE),
      .wr_hi   (wr_ok && wa == CSR_MCYCLEH),
      .wr_data (wd),
      .value   (mcycle)
   );

   csr_counter64 u_instret (
      .clk     (clk),
      .reset   (reset),
      .inc     (instret_pulse && !ir_inh),
      .wr_lo   (wr_ok && wa == CSR_MINSTRET),
      .wr_hi   (wr_ok && wa == CSR_MINSTRETH),
      .wr_data (wd),
      .value   (minstret)
   );

   // Trap outranks MRET, which outranks software writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         mstatus <= '0;
         mepc    <= '0;
         mcause  <= '0;
      end else if (trap_valid) begin
         mepc         <= {trap_pc[31:2], 2'b00};
         mcause       <= trap_cause;
         mstatus.mpie <= mstatus.mie;
         mstatus.mie  <= 1'b0;
      end else if (mret_valid) begin
         mstatus.mie  <= mstatus.mpie;
         mstatus.mpie <= 1'b1;
      end else if (wr_ok) begin
         if (wa == CSR_MSTATUS) begin
            mstatus.mie  <= wd[MSTATUS_MIE];
            mstatus.mpie <= wd[MSTATUS_MPIE];
         end
         if (wa == CSR_MEPC)   mepc   <= {wd[31:2], 2'b00};
         if (wa == CSR_MCAUSE) mcause <= wd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mtvec    <= MTVEC_RESET;
         mscratch <= '0;
      end else if (wr_ok) begin
         if (wa == CSR_MTVEC)    mtvec    <= {wd[31:2], 2'b00};
         if (wa == CSR_MSCRATCH) mscratch <= wd;
      end
   end

   always_comb begin
      rmux = '0;
      case (bus.read_address)
         CSR_MSTATUS: begin
            rmux[12:11]        = 2'b11;
            rmux[MSTATUS_MPIE] = mstatus.mpie;
            rmux[MSTATUS_MIE]  = mstatus.mie;
         end
         CSR_MISA:      rmux = MISA_VALUE;
         CSR_MTVEC:     rmux = mtvec;
         CSR_MSCRATCH:  rmux = mscratch;
         CSR_MEPC:      rmux = mepc;
         CSR_MCAUSE:    rmux = mcause;
`ifdef CSR_COUNTER_INHIBIT_EN
         CSR_MCOUNTINHIBIT: begin
            rmux[0] = cy_inh;
            rmux[2] = ir_inh;
         end
`endif
         CSR_MCYCLE, CSR_CYCLE, CSR_TIME:
            rmux = mcycle[31:0];
         CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH:
            rmux = mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:
            rmux = minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH:
            rmux = minstret[63:32];
         CSR_MHARTID:   rmux = HART_ID;
         default:       rmux = '0;
      endcase
   end

   assign bus.read_data = bus.read_enable ? rmux : 32'd0;

   assign mtvec_out = mtvec;
   assign mepc_out  = mepc;
   assign global_ie = mstatus.mie;

endmodule

// File: tb/tb_csr_register_file.sv
// Scoreboard bench for csr_register_file: stimulus queues expectations, a negedge monitor checks.
// Inhibit tests compile in when CSR_COUNTER_INHIBIT_EN is defined.
module tb_csr_register_file;
   import csr_register_file_pkg::*;

   localparam logic [31:0] MTV  = 32'h0000_1000;
   localparam logic [31:0] HART = 32'd3;
   localparam logic [31:0] MISA = 32'h4000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instret_pulse = 1'b0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_pc = '0;
   logic [31:0] trap_cause = '0;
   logic        mret_valid = 1'b0;
   logic [31:0] mtvec_out;
   logic [31:0] mepc_out;
   logic        global_ie;

   csr_register_file_if bus ();

   csr_register_file #(
      .HART_ID     (HART),
      .MISA_VALUE  (MISA),
      .MTVEC_RESET (MTV)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus.slave),
      .instret_pulse (instret_pulse),
      .trap_valid    (trap_valid),
      .trap_pc       (trap_pc),
      .trap_cause    (trap_cause),
      .mret_valid    (mret_valid),
      .mtvec_out     (mtvec_out),
      .mepc_out      (mepc_out),
      .global_ie     (global_ie)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      logic        ill;
      logic        side;
      logic [31:0] mtvec;
      logic [31:0] mepc;
      logic        gie;
   } rexp_t;

   rexp_t rq[$];
   logic  wq[$];
   int    tests = 0;
   int    failed = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.read_enable) begin
            if (rq.size() == 0) begin
               chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
               rexp_t e;
               e = rq.pop_front();
               chk($sformatf("rd_%h", e.addr), bus.read_data, e.data);
               chk($sformatf("rd_ill_%h", e.addr),
                   {31'd0, bus.illegal_access}, {31'd0, e.ill});
               if (e.side) begin
                  chk("mtvec_out", mtvec_out, e.mtvec);
                  chk("mepc_out", mepc_out, e.mepc);
                  chk("global_ie", {31'd0, global_ie}, {31'd0, e.gie});
               end
            end
         end else if (bus.write_enable) begin
            if (wq.size() == 0) begin
               chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
               logic ei;
               ei = wq.pop_front();
               chk($sformatf("wr_ill_%h", bus.write_address),
                   {31'd0, bus.illegal_access}, {31'd0, ei});
            end
         end else begin
            chk("idle_rdata", bus.read_data, 32'd0);
            chk("idle_ill", {31'd0, bus.illegal_access}, 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rdx(input logic [11:0] a, input logic [31:0] d,
                      input logic side, input logic [31:0] mt,
                      input logic [31:0] me, input logic g,
                      input logic ill);
      rexp_t e;
      e.addr = a; e.data = d; e.ill = ill;
      e.side = side; e.mtvec = mt; e.mepc = me; e.gie = g;
      rq.push_back(e);
      bus.read_enable  = 1'b1;
      bus.read_address = a;
      tick();
      bus.read_enable  = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] d,
                     input logic ill = 1'b0);
      rdx(a, d, 1'b0, '0, '0, 1'b0, ill);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d,
                     input logic ill = 1'b0);
      wq.push_back(ill);
      bus.write_enable  = 1'b1;
      bus.write_address = a;
      bus.write_data    = d;
      tick();
      bus.write_enable  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.read_enable   = 1'b0;
      bus.read_address  = '0;
      bus.write_enable  = 1'b0;
      bus.write_address = '0;
      bus.write_data    = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // reset state and free-running cycle count
      repeat (5) tick();
      rdx(CSR_MCYCLE, 32'd5, 1'b1, MTV, 32'd0, 1'b0, 1'b0);
      rd(CSR_MCYCLEH, 32'd0);
      rd(CSR_MSTATUS, 32'h0000_1800);
      rd(CSR_MISA, MISA);
      rd(CSR_MHARTID, HART);
      rd(CSR_MTVEC, MTV);
      rd(CSR_MEPC, 32'd0);
      rd(CSR_MCAUSE, 32'd0);
      rd(CSR_MINSTRET, 32'd0);

      // low-to-high carry
      wr(CSR_MCYCLE, 32'hFFFF_FFFF);
      wr(CSR_MCYCLEH, 32'd0);
      tick();
      rd(CSR_MCYCLE, 32'd0);
      rd(CSR_MCYCLEH, 32'd1);
      rd(CSR_CYCLEH, 32'd1);
      rd(CSR_TIMEH, 32'd1);

      // illegal accesses leave state alone
      wr(CSR_CYCLE, 32'h0000_DEAD, 1'b1);
      wr(CSR_CYCLEH, 32'h0000_BEEF, 1'b1);
      wr(CSR_MHARTID, 32'h55, 1'b1);
      rd(12'h7C0, 32'd0, 1'b1);
      rd(CSR_MCYCLEH, 32'd1);
      rd(CSR_MHARTID, HART);
`ifndef CSR_COUNTER_INHIBIT_EN
      wr(CSR_MCOUNTINHIBIT, 32'h5, 1'b1);
      rd(CSR_MCOUNTINHIBIT, 32'd0, 1'b1);
`endif

      // plain register writes and masking
      wr(CSR_MTVEC, 32'h0000_0203);
      rdx(CSR_MTVEC, 32'h0000_0200, 1'b1, 32'h0000_0200, 32'd0, 1'b0, 1'b0);
      wr(CSR_MSCRATCH, 32'hCAFE_BABE);
      rd(CSR_MSCRATCH, 32'hCAFE_BABE);
      wr(CSR_MEPC, 32'h0000_0057);
      rd(CSR_MEPC, 32'h0000_0054);
      wr(CSR_MISA, 32'h0);
      rd(CSR_MISA, MISA);
      wr(CSR_MSTATUS, 32'hFFFF_FFFF);
      rd(CSR_MSTATUS, 32'h0000_1888);
      wr(CSR_MSTATUS, 32'h0);
      rd(CSR_MSTATUS, 32'h0000_1800);

      // trap and mret
      wr(CSR_MSTATUS, 32'h88);
      rdx(CSR_MSTATUS, 32'h0000_1888, 1'b1, 32'h200, 32'h54, 1'b1, 1'b0);
      trap_valid = 1'b1;
      trap_pc    = 32'h0000_1002;
      trap_cause = MCAUSE_ILLEGAL_INSN;
      tick();
      trap_valid = 1'b0;
      rdx(CSR_MEPC, 32'h0000_1000, 1'b1, 32'h200, 32'h1000, 1'b0, 1'b0);
      rd(CSR_MCAUSE, 32'd2);
      rd(CSR_MSTATUS, 32'h0000_1880);
      mret_valid = 1'b1;
      tick();
      mret_valid = 1'b0;
      rdx(CSR_MSTATUS, 32'h0000_1888, 1'b1, 32'h200, 32'h1000, 1'b1, 1'b0);

      // trap beats mret and write in the same cycle
      trap_valid = 1'b1;
      mret_valid = 1'b1;
      trap_pc    = 32'h0000_2007;
      trap_cause = MCAUSE_ECALL_M;
      wr(CSR_MEPC, 32'h55);
      trap_valid = 1'b0;
      mret_valid = 1'b0;
      rdx(CSR_MEPC, 32'h0000_2004, 1'b1, 32'h200, 32'h2004, 1'b0, 1'b0);
      rd(CSR_MCAUSE, 32'd11);
      rd(CSR_MSTATUS, 32'h0000_1880);

      // instret: write wins over pulse, then counts
      instret_pulse = 1'b1;
      wr(CSR_MINSTRET, 32'd10);
      tick();
      tick();
      tick();
      instret_pulse = 1'b0;
      rd(CSR_MINSTRET, 32'd13);
      rd(CSR_INSTRET, 32'd13);
      rd(CSR_INSTRETH, 32'd0);
      wr(CSR_MINSTRET, 32'hFFFF_FFFF);
      wr(CSR_MINSTRETH, 32'hFFFF_FFFF);
      instret_pulse = 1'b1;
      tick();
      instret_pulse = 1'b0;
      rd(CSR_MINSTRET, 32'd0);
      rd(CSR_MINSTRETH, 32'd0);

`ifdef CSR_COUNTER_INHIBIT_EN
      wr(CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
      rd(CSR_MCOUNTINHIBIT, 32'h5);
      wr(CSR_MCYCLE, 32'd100);
      instret_pulse = 1'b1;
      wr(CSR_MINSTRET, 32'd7);
      tick();
      tick();
      rd(CSR_MINSTRET, 32'd7);
      rd(CSR_MCYCLE, 32'd100);
      instret_pulse = 1'b0;
      wr(CSR_MCOUNTINHIBIT, 32'd0);
      rd(CSR_MCYCLE, 32'd100);
      rd(CSR_MCYCLE, 32'd101);
      instret_pulse = 1'b1;
      tick();
      instret_pulse = 1'b0;
      rd(CSR_MINSTRET, 32'd8);
`endif

      // reset mid-operation overrides a pending trap and write
      reset         = 1'b1;
      trap_valid    = 1'b1;
      trap_pc       = 32'h0000_4444;
      instret_pulse = 1'b1;
      bus.write_enable  = 1'b1;
      bus.write_address = CSR_MSCRATCH;
      bus.write_data    = 32'h1234_5678;
      tick();
      reset         = 1'b0;
      trap_valid    = 1'b0;
      instret_pulse = 1'b0;
      bus.write_enable = 1'b0;
      rdx(CSR_MCYCLE, 32'd0, 1'b1, MTV, 32'd0, 1'b0, 1'b0);
      rd(CSR_MCYCLE, 32'd1);
      rd(CSR_MSTATUS, 32'h0000_1800);
      rd(CSR_MSCRATCH, 32'd0);
      rd(CSR_MINSTRET, 32'd0);
      rd(CSR_MCAUSE, 32'd0);

      tick();
      tick();
      chk("rq_drain", rq.size(), 32'd0);
      chk("wq_drain", wq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
